// File: rtl/fetch_pc_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch PC controller.
package fetch_pc_ctrl_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'hBFC0_0000;
  localparam logic [XLEN-1:0] EXC_VEC_DEF  = 32'hBFC0_0380;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_e;

  typedef enum logic [1:0] {
    RS_NONE   = 2'd0,
    RS_BRANCH = 2'd1,
    RS_ERET   = 2'd2,
    RS_EXC    = 2'd3
  } redir_src_e;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

  function automatic logic [XLEN-1:0] next_seq_pc(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

endpackage

// File: rtl/fetch_redirect_buf.sv
// Redirect source arbitration plus the pending-target register and the
// discard flag that marks an in-flight fetch as already superseded.
module fetch_redirect_buf
  import fetch_pc_ctrl_pkg::*;
#(
  parameter logic [XLEN-1:0] EXC_VEC = EXC_VEC_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_wb_exc,
  input  logic            i_id_eret,
  input  logic            i_id_redirect,
  input  logic [XLEN-1:0] i_cp0_epc,
  input  logic [XLEN-1:0] i_id_target,
  input  logic            i_pend_set,
  input  logic            i_pend_clr,
  input  logic            i_disc_set,
  input  logic            i_disc_clr,
  input  logic            i_disc_rst,
  output logic            o_redir_valid_c,
  output logic [XLEN-1:0] o_redir_target_c,
  output logic            o_pend_valid,
  output logic [XLEN-1:0] o_pend_target,
  output logic            o_discard
);

  redir_src_e      w_src;
  logic            r_pend_valid;
  logic [XLEN-1:0] r_pend_target;
  logic            r_discard;

  // Fixed priority: exception flush beats eret beats ID branch/jump.
  always_comb begin
    w_src = RS_NONE;
    if (i_wb_exc)           w_src = RS_EXC;
    else if (i_id_eret)     w_src = RS_ERET;
    else if (i_id_redirect) w_src = RS_BRANCH;
  end

  always_comb begin
    o_redir_valid_c  = (w_src != RS_NONE);
    o_redir_target_c = '0;
    case (w_src)
      RS_EXC:    o_redir_target_c = word_align(EXC_VEC);
      RS_ERET:   o_redir_target_c = word_align(i_cp0_epc);
      RS_BRANCH: o_redir_target_c = word_align(i_id_target);
      default:   o_redir_target_c = '0;
    endcase
  end

  // Set wins over clear so a fresh redirect is never lost to a same-cycle retire.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend_valid  <= 1'b0;
      r_pend_target <= '0;
      r_discard     <= i_disc_rst;
    end else begin
      if (i_pend_set) begin
        r_pend_valid  <= 1'b1;
        r_pend_target <= o_redir_target_c;
      end else if (i_pend_clr) begin
        r_pend_valid  <= 1'b0;
      end
      if (i_disc_set)      r_discard <= 1'b1;
      else if (i_disc_clr) r_discard <= 1'b0;
    end
  end

  assign o_pend_valid  = r_pend_valid;
  assign o_pend_target = r_pend_target;
  assign o_discard     = r_discard;

endmodule

// File: rtl/fetch_pc_ctrl.sv
// IF-stage PC controller: one outstanding request at a time, holds the fetched
// instruction until ID takes it, and steers the PC on redirects.
module fetch_pc_ctrl
  import fetch_pc_ctrl_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
  parameter logic [XLEN-1:0] EXC_VEC  = EXC_VEC_DEF
) (
  input  logic            clk,
  input  logic            reset,
  output logic            inst_req,
  output logic [XLEN-1:0] inst_addr,
  input  logic            inst_addr_ok,
  input  logic            inst_data_ok,
  input  logic [XLEN-1:0] inst_rdata,
  output logic            IF_valid,
  output logic [XLEN-1:0] IF_pc,
  output logic [XLEN-1:0] IF_inst,
  input  logic            ID_allowin,
  input  logic            ID_redirect,
  input  logic [XLEN-1:0] ID_target,
  input  logic            ID_eret,
  input  logic [XLEN-1:0] CP0_EPC,
  input  logic            WB_exc
);

  fetch_state_e    r_state, w_state_nxt;
  logic            r_inst_req;
  logic [XLEN-1:0] r_addr, w_addr_nxt;
  logic            r_if_valid, w_if_valid_nxt;
  logic [XLEN-1:0] r_if_pc, w_if_pc_nxt;
  logic [XLEN-1:0] r_if_inst, w_if_inst_nxt;
  logic            w_pend_set, w_pend_clr, w_disc_set, w_disc_clr;
  logic            w_redir_valid, w_pend_valid, w_discard;
  logic [XLEN-1:0] w_redir_target, w_pend_target;

  fetch_redirect_buf #(.EXC_VEC(EXC_VEC)) u_redirect_buf (
    .clk              (clk),
    .reset            (reset),
    .i_wb_exc         (WB_exc),
    .i_id_eret        (ID_eret),
    .i_id_redirect    (ID_redirect),
    .i_cp0_epc        (CP0_EPC),
    .i_id_target      (ID_target),
    .i_pend_set       (w_pend_set),
    .i_pend_clr       (w_pend_clr),
    .i_disc_set       (w_disc_set),
    .i_disc_clr       (w_disc_clr),
    .i_disc_rst       (r_state == S_WAIT),
    .o_redir_valid_c  (w_redir_valid),
    .o_redir_target_c (w_redir_target),
    .o_pend_valid     (w_pend_valid),
    .o_pend_target    (w_pend_target),
    .o_discard        (w_discard)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_REQ;
      r_addr     <= RESET_PC;
      r_inst_req <= 1'b0;
      r_if_valid <= 1'b0;
      r_if_pc    <= '0;
      r_if_inst  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_addr     <= w_addr_nxt;
      r_inst_req <= (w_state_nxt == S_REQ);
      r_if_valid <= w_if_valid_nxt;
      r_if_pc    <= w_if_pc_nxt;
      r_if_inst  <= w_if_inst_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_addr_nxt     = r_addr;
    w_if_valid_nxt = r_if_valid;
    w_if_pc_nxt    = r_if_pc;
    w_if_inst_nxt  = r_if_inst;
    w_pend_set     = 1'b0;
    w_pend_clr     = 1'b0;
    w_disc_set     = 1'b0;
    w_disc_clr     = 1'b0;
    case (r_state)
      S_REQ: begin
        // A response seen here belongs to a fetch cut short by reset.
        if (inst_data_ok) w_disc_clr = 1'b1;
        if (inst_addr_ok) begin
          w_state_nxt = S_WAIT;
          if (w_redir_valid) begin
            w_pend_set = 1'b1;
            w_disc_set = 1'b1;
          end else if (w_pend_valid) begin
            w_disc_set = 1'b1;
          end
        end else if (w_redir_valid) begin
          w_pend_set = 1'b1;
        end
      end
      S_WAIT: begin
        if (inst_data_ok) begin
          w_state_nxt = S_REQ;
          w_disc_clr  = 1'b1;
          w_pend_clr  = 1'b1;
          if (w_redir_valid) begin
            w_addr_nxt = w_redir_target;
          end else if (w_discard) begin
            w_addr_nxt = w_pend_valid ? w_pend_target : r_addr;
          end else begin
            w_state_nxt    = S_HOLD;
            w_if_valid_nxt = 1'b1;
            w_if_pc_nxt    = r_addr;
            w_if_inst_nxt  = inst_rdata;
          end
        end else if (w_redir_valid) begin
          w_pend_set = 1'b1;
          w_disc_set = 1'b1;
        end
      end
      S_HOLD: begin
        if (w_redir_valid) begin
          w_state_nxt    = S_REQ;
          w_if_valid_nxt = 1'b0;
          w_addr_nxt     = w_redir_target;
        end else if (ID_allowin) begin
          w_state_nxt    = S_REQ;
          w_if_valid_nxt = 1'b0;
          w_addr_nxt     = next_seq_pc(r_if_pc);
        end
      end
      default: w_state_nxt = S_REQ;
    endcase
  end

  assign inst_req  = r_inst_req;
  assign inst_addr = r_addr;
  assign IF_valid  = r_if_valid;
  assign IF_pc     = r_if_pc;
  assign IF_inst   = r_if_inst;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Scoreboard bench for fetch_pc_ctrl: expected fetch addresses and delivered
// instructions are queued as stimulus is planned and checked at each handshake.
module tb_fetch_pc_ctrl;

  logic        clk;
  logic        reset;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        IF_valid;
  logic [31:0] IF_pc;
  logic [31:0] IF_inst;
  logic        ID_allowin;
  logic        ID_redirect;
  logic [31:0] ID_target;
  logic        ID_eret;
  logic [31:0] CP0_EPC;
  logic        WB_exc;

  fetch_pc_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .IF_valid     (IF_valid),
    .IF_pc        (IF_pc),
    .IF_inst      (IF_inst),
    .ID_allowin   (ID_allowin),
    .ID_redirect  (ID_redirect),
    .ID_target    (ID_target),
    .ID_eret      (ID_eret),
    .CP0_EPC      (CP0_EPC),
    .WB_exc       (WB_exc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_total;
  int          n_bad;
  int          n_acc;
  int          n_deliv;
  logic        mem_accept;
  logic        mem_busy;
  logic [31:0] mem_addr;
  int          mem_lat;
  int          data_lat;
  logic [31:0] exp_addr_q[$];
  logic [63:0] exp_if_q[$];

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic push_fetch(input logic [31:0] a, input logic deliver);
    exp_addr_q.push_back(a);
    if (deliver) exp_if_q.push_back({a, inst_of(a)});
  endtask

  // One clock: drive the memory model from current outputs, then score the edge.
  task automatic tick();
    logic        s_req, s_ifv, s_allow, s_redir;
    logic [31:0] s_addr, s_ifpc, s_ifinst, e_addr;
    logic [63:0] e_if;
    s_req    = inst_req;
    s_addr   = inst_addr;
    s_ifv    = IF_valid;
    s_ifpc   = IF_pc;
    s_ifinst = IF_inst;
    s_allow  = ID_allowin;
    s_redir  = WB_exc | ID_eret | ID_redirect;
    inst_addr_ok = s_req && !mem_busy && mem_accept;
    inst_data_ok = mem_busy && (mem_lat == 0);
    inst_rdata   = inst_data_ok ? inst_of(mem_addr) : 32'hDEAD_BEEF;
    chk("one_outstanding", 32'(s_req & mem_busy), 32'd0);
    @(posedge clk);
    if (inst_data_ok)  mem_busy = 1'b0;
    else if (mem_busy) mem_lat--;
    if (inst_addr_ok) begin
      chk("addr_expected", 32'(exp_addr_q.size() != 0), 32'd1);
      if (exp_addr_q.size() != 0) begin
        e_addr = exp_addr_q.pop_front();
        chk("fetch_addr", s_addr, e_addr);
      end
      mem_busy = 1'b1;
      mem_addr = s_addr;
      mem_lat  = data_lat;
      n_acc++;
    end
    if (s_ifv && s_allow && !s_redir) begin
      chk("deliver_expected", 32'(exp_if_q.size() != 0), 32'd1);
      if (exp_if_q.size() != 0) begin
        e_if = exp_if_q.pop_front();
        chk("if_pc", s_ifpc, e_if[63:32]);
        chk("if_inst", s_ifinst, e_if[31:0]);
      end
      n_deliv++;
    end
    #1;
  endtask

  initial begin
    int a0, d0;
    n_total = 0; n_bad = 0; n_acc = 0; n_deliv = 0;
    mem_accept = 1'b0; mem_busy = 1'b0; mem_addr = '0; mem_lat = 0; data_lat = 0;
    reset = 1'b1; ID_allowin = 1'b0; ID_redirect = 1'b0; ID_target = '0;
    ID_eret = 1'b0; CP0_EPC = '0; WB_exc = 1'b0;
    inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = '0;

    // Reset values, then first cycle after release
    repeat (3) tick();
    chk("rst_inst_req", 32'(inst_req), 32'd0);
    chk("rst_inst_addr", inst_addr, 32'hBFC0_0000);
    chk("rst_if_valid", 32'(IF_valid), 32'd0);
    chk("rst_if_pc", IF_pc, 32'd0);
    chk("rst_if_inst", IF_inst, 32'd0);
    reset = 1'b0;
    tick();
    chk("rel_inst_req", 32'(inst_req), 32'd1);
    chk("rel_inst_addr", inst_addr, 32'hBFC0_0000);

    // Straight-line fetch: one instruction per three cycles
    push_fetch(32'hBFC0_0000, 1'b1);
    push_fetch(32'hBFC0_0004, 1'b1);
    push_fetch(32'hBFC0_0008, 1'b1);
    mem_accept = 1'b1; ID_allowin = 1'b1;
    a0 = n_acc; d0 = n_deliv;
    repeat (9) tick();
    chk("seq_accepts", 32'(n_acc - a0), 32'd3);
    chk("seq_delivers", 32'(n_deliv - d0), 32'd3);
    chk("seq_next_addr", inst_addr, 32'hBFC0_000C);

    // ID back-pressure in HOLD
    push_fetch(32'hBFC0_000C, 1'b1);
    ID_allowin = 1'b0;
    repeat (2) tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_valid", 32'(IF_valid), 32'd1);
      chk("hold_pc", IF_pc, 32'hBFC0_000C);
      chk("hold_inst", IF_inst, inst_of(32'hBFC0_000C));
      chk("hold_no_req", 32'(inst_req), 32'd0);
    end
    ID_allowin = 1'b1;
    tick();

    // Redirect while WAIT: response dropped
    push_fetch(32'hBFC0_0010, 1'b0);
    data_lat = 2;
    tick();
    ID_redirect = 1'b1; ID_target = 32'h8000_1000;
    tick();
    ID_redirect = 1'b0;
    repeat (2) begin
      tick();
      chk("wait_redir_ifv", 32'(IF_valid), 32'd0);
    end
    chk("wait_redir_addr", inst_addr, 32'h8000_1000);
    data_lat = 0;
    push_fetch(32'h8000_1000, 1'b1);
    repeat (3) tick();

    // Redirect concurrent with data_ok in WAIT
    push_fetch(32'h8000_1004, 1'b0);
    tick();
    ID_redirect = 1'b1; ID_target = 32'h8000_2000;
    tick();
    ID_redirect = 1'b0;
    chk("conc_ifv", 32'(IF_valid), 32'd0);
    chk("conc_addr", inst_addr, 32'h8000_2000);

    // All three sources in HOLD, with allowin: exception wins
    push_fetch(32'h8000_2000, 1'b0);
    ID_allowin = 1'b0;
    repeat (2) tick();
    chk("prio_hold_pc", IF_pc, 32'h8000_2000);
    WB_exc = 1'b1; ID_eret = 1'b1; CP0_EPC = 32'h8000_0100;
    ID_redirect = 1'b1; ID_target = 32'h8000_3000; ID_allowin = 1'b1;
    tick();
    WB_exc = 1'b0; ID_eret = 1'b0; ID_redirect = 1'b0; ID_allowin = 1'b0;
    chk("prio_exc_ifv", 32'(IF_valid), 32'd0);
    chk("prio_exc_addr", inst_addr, 32'hBFC0_0380);
    // eret beats branch
    push_fetch(32'hBFC0_0380, 1'b0);
    repeat (2) tick();
    ID_eret = 1'b1; ID_redirect = 1'b1;
    tick();
    ID_eret = 1'b0; ID_redirect = 1'b0;
    chk("prio_eret_addr", inst_addr, 32'h8000_0100);

    // Redirect during an unaccepted request: address held, that fetch dropped
    mem_accept = 1'b0;
    ID_redirect = 1'b1; ID_target = 32'h8000_4000;
    tick();
    ID_redirect = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("stall_addr", inst_addr, 32'h8000_0100);
      chk("stall_req", 32'(inst_req), 32'd1);
      tick();
    end
    chk("stall_addr_last", inst_addr, 32'h8000_0100);
    push_fetch(32'h8000_0100, 1'b0);
    push_fetch(32'h8000_4000, 1'b1);
    mem_accept = 1'b1; ID_allowin = 1'b1;
    repeat (5) tick();

    // PC wrap from 0xFFFFFFFC
    mem_accept = 1'b0;
    ID_redirect = 1'b1; ID_target = 32'hFFFF_FFFC;
    tick();
    ID_redirect = 1'b0;
    push_fetch(32'h8000_4004, 1'b0);
    push_fetch(32'hFFFF_FFFC, 1'b1);
    push_fetch(32'h0000_0000, 1'b1);
    mem_accept = 1'b1;
    repeat (8) tick();
    mem_accept = 1'b0;
    tick();
    chk("wrap_next_addr", inst_addr, 32'h0000_0004);
    chk("addr_q_drained", 32'(exp_addr_q.size()), 32'd0);
    chk("if_q_drained", 32'(exp_if_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_pc_ctrl.md
FETCH_PC_CTRL -- requirements
Module: fetch_pc_ctrl

Interface
REQ-001 Param RESET_PC, 32'hBFC0_0000, first fetch address after reset.
REQ-002 Param EXC_VEC, 32'hBFC0_0380, exception entry address.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 inst_req  output  1  instruction-memory request valid.
REQ-006 inst_addr  output  32  fetch address; word aligned.
REQ-007 inst_addr_ok  input  1  memory accepted request this cycle.
REQ-008 inst_data_ok  input  1  memory returns data this cycle.
REQ-009 inst_rdata  input  32  returned instruction.
REQ-010 IF_valid  output  1  IF stage holds a valid instruction for ID.
REQ-011 IF_pc  output  32  PC of the held instruction.
REQ-012 IF_inst  output  32  held instruction word.
REQ-013 ID_allowin  input  1  ID accepts IF instruction this cycle.
REQ-014 ID_redirect  input  1  ID-resolved jump/jr/taken-branch redirect valid.
REQ-015 ID_target  input  32  redirect target from nextpc datapath.
REQ-016 ID_eret  input  1  eret redirect.
REQ-017 CP0_EPC  input  32  eret target.
REQ-018 WB_exc  input  1  exception flush; redirect to EXC_VEC.

Function
REQ-019 FSM states: REQ (inst_req=1), WAIT (awaiting data_ok), HOLD (IF_valid=1, awaiting ID_allowin).
REQ-020 At most one outstanding memory request at any time.
REQ-021 REQ: inst_req=1, inst_addr stable until inst_addr_ok; on addr_ok go WAIT.
REQ-022 WAIT: on inst_data_ok capture inst_rdata/PC into IF_inst/IF_pc, go HOLD, IF_valid=1 next cycle.
REQ-023 HOLD: when ID_allowin=1, IF_valid drops/refreshes and FSM goes REQ with inst_addr=IF_pc+4 (mod 2^32 wrap).
REQ-024 Redirect priority same cycle: WB_exc > ID_eret > ID_redirect; winner target EXC_VEC / CP0_EPC / ID_target.
REQ-025 Redirect in HOLD: held instruction discarded (IF_valid=0 next cycle), FSM to REQ with redirect target.
REQ-026 Redirect in REQ without addr_ok: target latched in pending register; inst_addr not changed mid-request; on addr_ok set discard flag.
REQ-027 Redirect in REQ with addr_ok same cycle, or in WAIT: set discard flag, latch target.
REQ-028 data_ok with discard flag: data dropped, flag cleared, FSM to REQ with pending target; IF_valid stays 0.
REQ-029 Pending target used for next request, then cleared; a newer redirect overwrites pending by REQ-024 priority.
REQ-030 Redirect concurrent with data_ok (discard clear) in WAIT: returned data dropped, FSM to REQ with new target.
REQ-031 ID_allowin with IF_valid=0 has no effect; redirect in HOLD overrides ID_allowin same cycle.

Reset
REQ-032 reset=1: FSM=REQ, inst_addr=RESET_PC, inst_req=0 during reset, IF_valid=0, IF_pc=0, IF_inst=0, pending/discard cleared.
REQ-033 First cycle after reset deassertion: inst_req=1, inst_addr=RESET_PC.
REQ-034 reset mid-WAIT: in-flight response after reset is ignored only if discard is set; reset sets discard=1 when it interrupts WAIT.

Structure
REQ-035 Shared package: FSM state enum, RESET_PC, EXC_VEC constants, redirect-source encoding.
REQ-036 One sub-module fetch_redirect_buf: priority select of redirect sources plus pending target/valid register and discard flag.

Verification
REQ-037 Reset release, addr_ok+data_ok immediate, ID_allowin=1 -> addresses BFC00000, BFC00004, BFC00008 one instruction per 3 cycles, IF_pc matches.
REQ-038 ID_allowin=0 for 5 cycles in HOLD -> IF_valid, IF_pc, IF_inst stable, no inst_req.
REQ-039 ID_redirect target 0x80001000 while WAIT -> returned data dropped, next inst_addr=0x80001000, IF_valid never shows stale PC.
REQ-040 WB_exc, ID_eret (EPC=0x80000100), ID_redirect same cycle in HOLD -> next inst_addr=BFC00380.
REQ-041 Redirect while inst_req held without addr_ok for 3 cycles -> inst_addr unchanged until addr_ok, that fetch discarded, then target fetched.
REQ-042 IF_pc=0xFFFFFFFC accepted -> next inst_addr=0x00000000.
